// File: rtl/as_mac_lut.sv
// Anti-spoof source-MAC table: req/ack register read/write port plus a 2-stage lookup (verdict 2 cycles after request).
// Optional AS_MAC_LUT_LEARN_EN: learn unknown sources into a round-robin slot on a lookup miss.
module as_mac_lut #(
  parameter int NUM_OUTPUT_QUEUES = 5,
  parameter int LUT_DEPTH_BITS    = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [LUT_DEPTH_BITS-1:0]    rd_addr,
  input  logic                         rd_req,
  output logic [NUM_OUTPUT_QUEUES-1:0] rd_oq,
  output logic                         rd_wr_protect,
  output logic [47:0]                  rd_mac,
  output logic                         rd_ack,
  input  logic [LUT_DEPTH_BITS-1:0]    wr_addr,
  input  logic                         wr_req,
  input  logic [NUM_OUTPUT_QUEUES-1:0] wr_oq,
  input  logic                         wr_protect,
  input  logic [47:0]                  wr_mac,
  output logic                         wr_ack,
  input  logic                         lookup_req,
  input  logic [47:0]                  lookup_mac,
  input  logic [NUM_OUTPUT_QUEUES-1:0] lookup_src_port,
  output logic                         lookup_done,
  output logic                         lookup_pass,
  output logic [NUM_OUTPUT_QUEUES-1:0] lookup_oq,
  output logic                         lut_hit,
  output logic                         lut_miss
);
  localparam int DEPTH = 1 << LUT_DEPTH_BITS;

  typedef enum logic [1:0] {IDLE, RD_ACK, WR_ACK} state_t;

  state_t state, state_nxt;
  logic   reg_we, reg_re;

  logic [47:0]                  mac_tbl  [DEPTH];
  logic [NUM_OUTPUT_QUEUES-1:0] oq_tbl   [DEPTH];
  logic                         prot_tbl [DEPTH];

  logic                         s1_vld;
  logic [47:0]                  s1_mac;
  logic [NUM_OUTPUT_QUEUES-1:0] s1_port;
  logic                         hit;
  logic [NUM_OUTPUT_QUEUES-1:0] hit_oq;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    reg_we    = 1'b0;
    reg_re    = 1'b0;
    rd_ack    = 1'b0;
    wr_ack    = 1'b0;
    case (state)
      IDLE: begin
        if (wr_req) begin
          reg_we    = 1'b1;
          state_nxt = WR_ACK;
        end else if (rd_req) begin
          reg_re    = 1'b1;
          state_nxt = RD_ACK;
        end
      end
      RD_ACK: begin
        rd_ack = 1'b1;
        if (!rd_req) state_nxt = IDLE;
      end
      WR_ACK: begin
        wr_ack = 1'b1;
        if (!wr_req) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_oq         <= '0;
      rd_wr_protect <= 1'b0;
      rd_mac        <= '0;
    end else if (reg_re) begin
      rd_oq         <= oq_tbl[rd_addr];
      rd_wr_protect <= prot_tbl[rd_addr];
      rd_mac        <= mac_tbl[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld  <= 1'b0;
      s1_mac  <= '0;
      s1_port <= '0;
    end else begin
      s1_vld  <= lookup_req;
      s1_mac  <= lookup_mac;
      s1_port <= lookup_src_port;
    end
  end

  // Scan high to low so the lowest matching index is the last assignment.
  always_comb begin
    hit    = 1'b0;
    hit_oq = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (oq_tbl[i] != '0 && mac_tbl[i] == s1_mac) begin
        hit    = 1'b1;
        hit_oq = oq_tbl[i];
      end
    end
  end

`ifdef AS_MAC_LUT_LEARN_EN
  localparam logic [LUT_DEPTH_BITS-1:0] PTR_ONE = 1;
  logic [LUT_DEPTH_BITS-1:0] learn_ptr;
  logic                      learn_we;

  // A register write to the same slot takes precedence over the learn.
  assign learn_we = s1_vld && !hit && !prot_tbl[learn_ptr] && !(reg_we && wr_addr == learn_ptr);

  always_ff @(posedge clk) begin
    if (reset)              learn_ptr <= '0;
    else if (s1_vld && !hit) learn_ptr <= learn_ptr + PTR_ONE;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mac_tbl[i]  <= '0;
        oq_tbl[i]   <= '0;
        prot_tbl[i] <= 1'b0;
      end
    end else begin
`ifdef AS_MAC_LUT_LEARN_EN
      if (learn_we) begin
        mac_tbl[learn_ptr]  <= s1_mac;
        oq_tbl[learn_ptr]   <= s1_port;
        prot_tbl[learn_ptr] <= 1'b0;
      end
`endif
      if (reg_we) begin
        mac_tbl[wr_addr]  <= wr_mac;
        oq_tbl[wr_addr]   <= wr_oq;
        prot_tbl[wr_addr] <= wr_protect;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lookup_done <= 1'b0;
      lookup_pass <= 1'b0;
      lookup_oq   <= '0;
      lut_hit     <= 1'b0;
      lut_miss    <= 1'b0;
    end else begin
      lookup_done <= s1_vld;
      lut_hit     <= s1_vld && hit;
      lut_miss    <= s1_vld && !hit;
      if (s1_vld) begin
        lookup_oq   <= hit_oq;
        lookup_pass <= hit ? |(hit_oq & s1_port) : 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_as_mac_lut.sv
// Bench for as_mac_lut: directed register/lookup scenarios, then random lookups against a table model.
module tb_as_mac_lut;
  localparam int NOQ   = 5;
  localparam int DB    = 4;
  localparam int DEPTH = 16;
  localparam int NRAND = 300;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [DB-1:0]  rd_addr = '0;
  logic           rd_req = 1'b0;
  logic [NOQ-1:0] rd_oq;
  logic           rd_wr_protect;
  logic [47:0]    rd_mac;
  logic           rd_ack;
  logic [DB-1:0]  wr_addr = '0;
  logic           wr_req = 1'b0;
  logic [NOQ-1:0] wr_oq = '0;
  logic           wr_protect = 1'b0;
  logic [47:0]    wr_mac = '0;
  logic           wr_ack;
  logic           lookup_req = 1'b0;
  logic [47:0]    lookup_mac = '0;
  logic [NOQ-1:0] lookup_src_port = '0;
  logic           lookup_done, lookup_pass, lut_hit, lut_miss;
  logic [NOQ-1:0] lookup_oq;

  as_mac_lut #(.NUM_OUTPUT_QUEUES(NOQ), .LUT_DEPTH_BITS(DB)) dut (
    .clk(clk), .reset(reset),
    .rd_addr(rd_addr), .rd_req(rd_req), .rd_oq(rd_oq), .rd_wr_protect(rd_wr_protect),
    .rd_mac(rd_mac), .rd_ack(rd_ack),
    .wr_addr(wr_addr), .wr_req(wr_req), .wr_oq(wr_oq), .wr_protect(wr_protect),
    .wr_mac(wr_mac), .wr_ack(wr_ack),
    .lookup_req(lookup_req), .lookup_mac(lookup_mac), .lookup_src_port(lookup_src_port),
    .lookup_done(lookup_done), .lookup_pass(lookup_pass), .lookup_oq(lookup_oq),
    .lut_hit(lut_hit), .lut_miss(lut_miss)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [47:0]    m_mac  [DEPTH];
  logic [NOQ-1:0] m_oq   [DEPTH];
  logic           m_prot [DEPTH];
  int             m_ptr;
  logic [47:0]    pool   [8];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_mac[i] = '0; m_oq[i] = '0; m_prot[i] = 1'b0;
    end
    m_ptr = 0;
  endtask

  function automatic int model_find(input logic [47:0] mac);
    for (int i = 0; i < DEPTH; i++)
      if (m_oq[i] != '0 && m_mac[i] == mac) return i;
    return -1;
  endfunction

  task automatic do_write(input int a, input logic p, input logic [NOQ-1:0] oq, input logic [47:0] mac);
    wr_addr = a[DB-1:0]; wr_protect = p; wr_oq = oq; wr_mac = mac; wr_req = 1'b1;
    tick();
    check("wr_ack_rise", wr_ack, 1);
    m_mac[a] = mac; m_oq[a] = oq; m_prot[a] = p;
    wr_req = 1'b0;
    tick();
    check("wr_ack_fall", wr_ack, 0);
  endtask

  task automatic do_read(input int a, output logic p, output logic [NOQ-1:0] oq, output logic [47:0] mac);
    rd_addr = a[DB-1:0]; rd_req = 1'b1;
    tick();
    check("rd_ack_rise", rd_ack, 1);
    p = rd_wr_protect; oq = rd_oq; mac = rd_mac;
    rd_req = 1'b0;
    tick();
    check("rd_ack_fall", rd_ack, 0);
  endtask

  task automatic lookup_one(input logic [47:0] mac, input logic [NOQ-1:0] port);
    lookup_req = 1'b1; lookup_mac = mac; lookup_src_port = port;
    tick();
    lookup_req = 1'b0;
    check("lk_early", lookup_done, 0);
    tick();
  endtask

  logic           r_p;
  logic [NOQ-1:0] r_oq;
  logic [47:0]    r_mac;
  logic           p_vld, e_vld, e_pass;
  logic [47:0]    p_mac;
  logic [NOQ-1:0] p_port, e_oq;
  int             e_idx;

  initial begin
    for (int i = 0; i < 8; i++) pool[i] = 48'h0200_0000_0000 + 48'(i * 17);
    model_clear();
    repeat (3) tick();
    check("rst_rd_ack", rd_ack, 0);
    check("rst_wr_ack", wr_ack, 0);
    check("rst_done", lookup_done, 0);
    check("rst_hitmiss", {lut_hit, lut_miss, lookup_pass, lookup_oq}, 0);
    check("rst_rd_data", {rd_wr_protect, rd_oq, rd_mac}, 0);
    reset = 1'b0;
    tick();

    do_read(3, r_p, r_oq, r_mac);
    check("rd3_zero", {r_p, r_oq, r_mac}, 0);

    do_write(2, 1'b1, 5'b00100, 48'h0011_2233_4455);
    do_read(2, r_p, r_oq, r_mac);
    check("rd2_prot", r_p, 1);
    check("rd2_oq", r_oq, 5'b00100);
    check("rd2_mac", r_mac, 48'h0011_2233_4455);

    lookup_one(48'h0011_2233_4455, 5'b00100);
    check("hit_done", lookup_done, 1);
    check("hit_pass", lookup_pass, 1);
    check("hit_oq", lookup_oq, 5'b00100);
    check("hit_flags", {lut_hit, lut_miss}, 2'b10);
    tick();
    check("done_pulse", lookup_done, 0);

    lookup_one(48'h0011_2233_4455, 5'b00001);
    check("spoof_pass", lookup_pass, 0);
    check("spoof_flags", {lut_hit, lut_miss}, 2'b10);

    lookup_one(48'hAAAA_BBBB_CCCC, 5'b00010);
    check("miss_done", lookup_done, 1);
    check("miss_pass", lookup_pass, 1);
    check("miss_oq", lookup_oq, 0);
    check("miss_flags", {lut_hit, lut_miss}, 2'b01);
`ifdef AS_MAC_LUT_LEARN_EN
    lookup_one(48'hAAAA_BBBB_CCCC, 5'b00010);
    check("learn_hit", lut_hit, 1);
    check("learn_oq", lookup_oq, 5'b00010);
    do_read(0, r_p, r_oq, r_mac);
    check("learn_slot0", {r_p, r_oq, r_mac}, {1'b0, 5'b00010, 48'hAAAA_BBBB_CCCC});
`endif

    // Write commits at the end of the compare cycle, so that compare still sees the old table.
    lookup_req = 1'b1; lookup_mac = 48'h0A0B_0C0D_0E0F; lookup_src_port = 5'b01000;
    tick();
    lookup_req = 1'b0;
    wr_addr = 5; wr_mac = 48'h0A0B_0C0D_0E0F; wr_oq = 5'b01000; wr_protect = 1'b0; wr_req = 1'b1;
    tick();
    check("race_miss", {lookup_done, lut_hit, lut_miss}, 3'b101);
    check("race_wr_ack", wr_ack, 1);
    wr_req = 1'b0;
    tick();
    lookup_one(48'h0A0B_0C0D_0E0F, 5'b01000);
    check("race_after", {lookup_done, lut_hit, lookup_pass}, 3'b111);
    check("race_after_oq", lookup_oq, 5'b01000);

    rd_addr = 7; wr_addr = 7; wr_mac = 48'h7777_0000_1234; wr_oq = 5'b10001; wr_protect = 1'b1;
    rd_req = 1'b1; wr_req = 1'b1;
    tick();
    check("both_wr_first", {wr_ack, rd_ack}, 2'b10);
    wr_req = 1'b0;
    tick();
    check("both_gap", {wr_ack, rd_ack}, 2'b00);
    tick();
    check("both_rd_ack", rd_ack, 1);
    check("both_rd_data", {rd_wr_protect, rd_oq, rd_mac}, {1'b1, 5'b10001, 48'h7777_0000_1234});
    rd_req = 1'b0;
    tick();
    check("both_rd_fall", rd_ack, 0);

    rd_addr = 2; rd_req = 1'b1;
    tick();
    check("rst_case_ack", rd_ack, 1);
    lookup_req = 1'b1; lookup_mac = 48'h0011_2233_4455; lookup_src_port = 5'b00100;
    tick();
    lookup_req = 1'b0; reset = 1'b1;
    tick();
    check("midrst_rd_ack", rd_ack, 0);
    check("midrst_done", lookup_done, 0);
    rd_req = 1'b0; reset = 1'b0;
    tick();
    check("postrst_done", lookup_done, 0);
    check("postrst_ack", rd_ack, 0);
    model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      do_read(i, r_p, r_oq, r_mac);
      check("postrst_tbl", {r_p, r_oq, r_mac}, 0);
    end

    for (int i = 0; i < DEPTH; i++)
      do_write(i, 1'($urandom_range(0, 1)), NOQ'($urandom_range(0, 31)), pool[$urandom_range(0, 7)]);

    p_vld = 1'b0; p_mac = '0; p_port = '0;
    for (int c = 0; c < NRAND + 2; c++) begin
      // Verdict for the lookup now in flight, judged against the table as it stands this cycle.
      e_vld = p_vld; e_idx = -1; e_oq = '0; e_pass = 1'b1;
      if (p_vld) begin
        e_idx = model_find(p_mac);
        if (e_idx >= 0) begin
          e_oq = m_oq[e_idx];
          e_pass = |(m_oq[e_idx] & p_port);
        end
`ifdef AS_MAC_LUT_LEARN_EN
        else begin
          if (!m_prot[m_ptr]) begin
            m_mac[m_ptr] = p_mac; m_oq[m_ptr] = p_port; m_prot[m_ptr] = 1'b0;
          end
          m_ptr = (m_ptr + 1) % DEPTH;
        end
`endif
      end
      lookup_req = (c < NRAND) && ($urandom_range(0, 3) != 0);
      lookup_mac = ($urandom_range(0, 3) == 0) ? {16'hBEEF, 32'($urandom)} : pool[$urandom_range(0, 7)];
      lookup_src_port = NOQ'(1 << $urandom_range(0, NOQ - 1));
      p_vld = lookup_req; p_mac = lookup_mac; p_port = lookup_src_port;
      tick();
      check("rnd_done", lookup_done, e_vld);
      if (e_vld) begin
        check("rnd_pass", lookup_pass, e_pass);
        check("rnd_oq", lookup_oq, e_oq);
        check("rnd_flags", {lut_hit, lut_miss}, (e_idx >= 0) ? 2'b10 : 2'b01);
      end else begin
        check("rnd_idle_flags", {lut_hit, lut_miss}, 2'b00);
      end
    end
    lookup_req = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      do_read(i, r_p, r_oq, r_mac);
      check("final_tbl", {r_p, r_oq, r_mac}, {m_prot[i], m_oq[i], m_mac[i]});
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
